// File: rtl/score_pkg.sv
// Shared types and helpers for the score keeper: round FSM encoding and
// saturating score arithmetic.
package score_pkg;

   // Round FSM state width and encoding
   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Apply add/sub to a score and clamp the result to [0, max_val]
   function automatic int unsigned sat_add_sub(input int unsigned cur,
                                               input int unsigned add,
                                               input int unsigned sub,
                                               input int unsigned max_val);
      longint acc;
      acc = longint'(cur) + longint'(add) - longint'(sub);
      if (acc < 0) begin
         return 0;
      end else if (acc > longint'(max_val)) begin
         return max_val;
      end else begin
         return 32'(acc);
      end
   endfunction

endpackage : score_pkg

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector. A level held
// high produces exactly one pulse; it re-arms only after returning low.
module edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse_c
);

   logic s1;
   logic s2;
   logic s3;

   // Synchroniser chain plus one delay stage for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign pulse_c = s2 & ~s3;

endmodule : edge_sync

// File: rtl/score_keeper.sv
// Multi-player score keeper for the duck-shooting game.
// Optional feature: define SCORE_COMBO_EN to enable per-player hit streaks
// that double the hit points once COMBO_LEN consecutive hits are reached.
module score_keeper
   import score_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned PLAYERS      = 2,
   parameter int unsigned HIT_POINTS   = 1,
   parameter int unsigned MISS_PENALTY = 0,
   parameter int unsigned COMBO_LEN    = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     game_start,
   input  logic                     game_over,
   input  logic [PLAYERS-1:0]       hit,
   input  logic [PLAYERS-1:0]       miss,
   output logic [PLAYERS*WIDTH-1:0] score,
   output logic [WIDTH-1:0]         high_score,
   output logic                     new_high,
   output logic [STATE_W-1:0]       state
);

   localparam int unsigned MAX_SCORE = (32'd1 << WIDTH) - 32'd1;

   // Reject unsupported configurations at elaboration
   if (PLAYERS < 1 || PLAYERS > 4 || COMBO_LEN < 1 || WIDTH < 1 || WIDTH > 30) begin : g_param_check
      $error("score_keeper: unsupported parameter combination");
   end

   logic [PLAYERS-1:0] hit_pulse_c;
   logic [PLAYERS-1:0] miss_pulse_c;

   state_e state_q;
   state_e state_d;
   logic   round_start_c;
   logic   round_end_c;

   logic [WIDTH-1:0] score_q [PLAYERS];
   logic [WIDTH-1:0] next_score_c [PLAYERS];
   int unsigned      hit_pts_c [PLAYERS];
   logic [WIDTH-1:0] max_score_c;
   logic [WIDTH-1:0] high_score_q;
   logic             new_high_q;

   // Per-player event conditioning for hit and miss levels
   for (genvar p = 0; p < PLAYERS; p++) begin : g_sync
      edge_sync u_hit_sync (
         .clk     (clk),
         .rst     (rst),
         .din     (hit[p]),
         .pulse_c (hit_pulse_c[p])
      );
      edge_sync u_miss_sync (
         .clk     (clk),
         .rst     (rst),
         .din     (miss[p]),
         .pulse_c (miss_pulse_c[p])
      );
   end

   // Round FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Round FSM next state; game_over has priority over game_start in PLAY
   always_comb begin
      state_d       = state_q;
      round_start_c = 1'b0;
      round_end_c   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (game_start) begin
               state_d       = PLAY;
               round_start_c = 1'b1;
            end
         end
         PLAY: begin
            if (game_over) begin
               state_d     = DONE;
               round_end_c = 1'b1;
            end
         end
         DONE: begin
            if (game_start) begin
               state_d       = PLAY;
               round_start_c = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef SCORE_COMBO_EN
   localparam int unsigned STREAK_W = (COMBO_LEN < 2) ? 1 : $clog2(COMBO_LEN + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(COMBO_LEN);

   logic [STREAK_W-1:0] streak_q [PLAYERS];

   // Hit points from the pre-update streak: doubled once the streak is full
   always_comb begin
      for (int p = 0; p < PLAYERS; p++) begin
         hit_pts_c[p] = 0;
         if (hit_pulse_c[p]) begin
            hit_pts_c[p] = (streak_q[p] == STREAK_MAX) ? 2 * HIT_POINTS : HIT_POINTS;
         end
      end
   end

   // Streak counters: saturate on hits, clear on miss or round start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < PLAYERS; p++) begin
            streak_q[p] <= '0;
         end
      end else if (round_start_c) begin
         for (int p = 0; p < PLAYERS; p++) begin
            streak_q[p] <= '0;
         end
      end else if (state_q == PLAY) begin
         for (int p = 0; p < PLAYERS; p++) begin
            if (miss_pulse_c[p]) begin
               streak_q[p] <= '0;
            end else if (hit_pulse_c[p] && (streak_q[p] != STREAK_MAX)) begin
               streak_q[p] <= streak_q[p] + STREAK_W'(1);
            end
         end
      end
   end
`else
   // Flat hit points, no streak tracking
   always_comb begin
      for (int p = 0; p < PLAYERS; p++) begin
         hit_pts_c[p] = hit_pulse_c[p] ? HIT_POINTS : 0;
      end
   end
`endif

   // Net delta per player, clamped to the representable score range
   always_comb begin
      for (int p = 0; p < PLAYERS; p++) begin
         next_score_c[p] = WIDTH'(sat_add_sub(32'(score_q[p]),
                                              hit_pts_c[p],
                                              miss_pulse_c[p] ? MISS_PENALTY : 0,
                                              MAX_SCORE));
      end
   end

   // Score registers: clear at round start, advance only while playing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < PLAYERS; p++) begin
            score_q[p] <= '0;
         end
      end else if (round_start_c) begin
         for (int p = 0; p < PLAYERS; p++) begin
            score_q[p] <= '0;
         end
      end else if (state_q == PLAY) begin
         for (int p = 0; p < PLAYERS; p++) begin
            score_q[p] <= next_score_c[p];
         end
      end
   end

   // Best score among players at the current moment
   always_comb begin
      max_score_c = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         if (score_q[p] > max_score_c) begin
            max_score_c = score_q[p];
         end
      end
   end

   // High score captured when a round ends; strictly greater wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         high_score_q <= '0;
         new_high_q   <= 1'b0;
      end else begin
         new_high_q <= 1'b0;
         if (round_end_c && (max_score_c > high_score_q)) begin
            high_score_q <= max_score_c;
            new_high_q   <= 1'b1;
         end
      end
   end

   // Flatten per-player scores onto the output bus
   for (genvar p = 0; p < PLAYERS; p++) begin : g_score_out
      assign score[p*WIDTH +: WIDTH] = score_q[p];
   end

   assign high_score = high_score_q;
   assign new_high   = new_high_q;
   assign state      = state_q;

endmodule : score_keeper
